uart_rx: RTL and testbench

//   Serial receiver; consumes the LSB-first serial stream produced by the transmit shift register.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx_sync_ff.sv | 21 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side valid/ready port of the UART receiver plus its error pulses.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ready);
`else
    modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
`endif
endinterface

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= {STAGES{RESET_VAL}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised line, mid-bit sampling, stop check, valid/ready byte output.
// Optional parity stage and parity_err pulse when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD   = 1'b0
`endif
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     serial_i,
    uart_rx_if.master rx
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 line_s;
    rx_state_t            state, state_nx;
    logic [TMR_W-1:0]     timer, timer_nx;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shift_reg, shift_nx;
    logic                 done, done_nx;
    logic                 ferr_nx;
    logic                 load_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_nx;
    logic                 parity_bad_c;
`endif

    uart_rx_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_i),
        .q     (line_s)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, bit timer, shift register and stop-bit verdict
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        bit_idx_nx = bit_idx;
        shift_nx   = shift_reg;
        done_nx    = 1'b0;
        ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx     = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!line_s) begin
                    state_nx = START;
                    timer_nx = HALF_LOAD;
                end
            end
            START: begin
                if (timer == '0) begin
                    if (!line_s) begin
                        state_nx   = DATA;
                        timer_nx   = FULL_LOAD;
                        bit_idx_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            DATA: begin
                if (timer == '0) begin
                    shift_nx = {line_s, shift_reg[DATA_BITS-1:1]};
                    timer_nx = FULL_LOAD;
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + IDX_W'(1);
                    end
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer == '0) begin
                    par_nx   = line_s;
                    timer_nx = FULL_LOAD;
                    state_nx = STOP;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
`endif
            STOP: begin
                if (timer == '0) begin
                    if (line_s) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
                    end
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            BREAK: begin
                if (line_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A finished byte loads only if the output slot is free or being drained this cycle
    assign load_c = done && (!rx.rx_valid || rx.rx_ready);
`ifdef UART_RX_PARITY_EN
    assign parity_bad_c = ((^shift_reg) ^ par_bit) != PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            timer        <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            done         <= 1'b0;
            rx.rx_data   <= '0;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            rx.parity_err <= 1'b0;
`endif
        end else begin
            timer        <= timer_nx;
            bit_idx      <= bit_idx_nx;
            shift_reg    <= shift_nx;
            done         <= done_nx;
            rx.frame_err <= ferr_nx;
            rx.overrun   <= done && rx.rx_valid && !rx.rx_ready;
            if (load_c) begin
                rx.rx_data  <= shift_reg;
                rx.rx_valid <= 1'b1;
            end else if (rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            par_bit       <= par_nx;
            rx.parity_err <= (done || ferr_nx) && parity_bad_c;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, monitor pops expected bytes on each transfer.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serial_i = 1'b1;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (8),
        .SYNC_STAGES  (2)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD   (1'b0)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .serial_i (serial_i),
        .rx       (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid && bus.rx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %02h, none expected", bus.rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.rx_data !== mon_exp) begin
                        fails++;
                        $display("FAIL rx_data: got %02h, expected %02h", bus.rx_data, mon_exp);
                    end
                end
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (bus.parity_err) perr_cnt++;
`endif
        end
    end

    task automatic drive(input logic v);
        serial_i = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_b, input bit has_par, input logic par_b);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(b[i]);
        if (has_par) drive(par_b);
        drive(stop_b);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.rx_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_valid",  32'(bus.rx_valid),  32'h0);
        chk("reset_rx_data",   32'(bus.rx_data),   32'h0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'h0);
        chk("reset_overrun",   32'(bus.overrun),   32'h0);
        chk("reset_state",     32'(dut.state),     32'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);

        // Clean frame with consumer ready
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("t1_delivered", 32'(exp_q.size()), 32'd0);
        chk("t1_frame_err", 32'(ferr_cnt), 32'd0);
        chk("t1_overrun",   32'(ovr_cnt),  32'd0);

        // Short low glitch must not start a frame
        serial_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(20);
        chk("t2_state_idle", 32'(dut.state), 32'(IDLE));
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("t2_delivered", 32'(exp_q.size()), 32'd0);

        // Bad stop bit, then line held low
        send(8'h81, 1'b0, 1'b0, 1'b0);
        serial_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t3_frame_err", 32'(ferr_cnt), 32'd1);
        chk("t3_in_break",  32'(dut.state), 32'(BREAK));
        idle(20);
        chk("t3_frame_err_after", 32'(ferr_cnt), 32'd1);
        chk("t3_state_idle", 32'(dut.state), 32'(IDLE));

        // Overrun: consumer stalled across two frames
        bus.rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(5);
        send(8'hC3, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("t4_valid_held", 32'(bus.rx_valid), 32'h1);
        chk("t4_data_held",  32'(bus.rx_data),  32'h3C);
        chk("t4_overrun",    32'(ovr_cnt),      32'd1);
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_drained",      32'(exp_q.size()), 32'd0);
        chk("t4_valid_clear",  32'(bus.rx_valid), 32'h0);

        // Reset in the middle of a data phase
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_rx_valid",  32'(bus.rx_valid),  32'h0);
        chk("t5_rx_data",   32'(bus.rx_data),   32'h0);
        chk("t5_frame_err", 32'(bus.frame_err), 32'h0);
        chk("t5_overrun",   32'(bus.overrun),   32'h0);
        chk("t5_state",     32'(dut.state),     32'(IDLE));
        reset = 1'b0;
        idle(20);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("t5_delivered", 32'(exp_q.size()), 32'd0);
        chk("t5_data",      32'(bus.rx_data),  32'h5A);
        chk("t5_ferr_cnt",  32'(ferr_cnt),     32'd1);
        chk("t5_ovr_cnt",   32'(ovr_cnt),      32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("t6_parity_ok", 32'(perr_cnt), 32'd0);
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        chk("t6_parity_err", 32'(perr_cnt),     32'd1);
        chk("t6_delivered",  32'(exp_q.size()), 32'd0);
        chk("t6_data",       32'(bus.rx_data),  32'h07);
`else
        chk("no_parity_pulses", 32'(perr_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
